// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op codes, engine states and iteration constants.
package md_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int MD_ITERS   = 32;
  localparam int MD_LATENCY = 33;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation: magnitude at accept, sign restore at fix-up.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/md_iter_engine.sv
// Iterative radix-2 multiply / restoring divide engine feeding the HI/LO block.
module md_iter_engine
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e            state_r, state_s;
  logic [5:0]           cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     opnd_r;
  logic [WIDTH-1:0]     a_raw_r;
  logic                 is_div_r, sign_q_r, sign_r_r, dbz_r;
  logic                 busy_r, done_r;
  logic [WIDTH-1:0]     hi_r, lo_r;

  logic                 start_ok_s, accept_s, signed_s;
  logic [WIDTH-1:0]     abs_a_s, abs_b_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s, div_next_s;
  logic [WIDTH:0]       div_rem_s;
  logic [WIDTH+1:0]     div_diff_s;
  logic                 div_ge_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quot_fix_s, rem_fix_s;
  logic [WIDTH-1:0]     res_hi_s, res_lo_s;

  // A start is only meaningful for the four defined op codes and when not being aborted.
  assign start_ok_s = start & (op[2] == 1'b0) & ~cancel;
  assign signed_s   = (op[0] == 1'b0);

  md_sign_fix #(.W(WIDTH)) u_abs_a (
    .value (src_a),
    .negate(signed_s & src_a[WIDTH-1]),
    .result(abs_a_s)
  );

  md_sign_fix #(.W(WIDTH)) u_abs_b (
    .value (src_b),
    .negate(signed_s & src_b[WIDTH-1]),
    .result(abs_b_s)
  );

  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .value (acc_r),
    .negate(sign_q_r),
    .result(prod_fix_s)
  );

  md_sign_fix #(.W(WIDTH)) u_fix_quot (
    .value (acc_r[WIDTH-1:0]),
    .negate(sign_q_r),
    .result(quot_fix_s)
  );

  md_sign_fix #(.W(WIDTH)) u_fix_rem (
    .value (acc_r[2*WIDTH-1:WIDTH]),
    .negate(sign_r_r),
    .result(rem_fix_s)
  );

  // One iteration step for both algorithms; the divide keeps a 33-bit partial remainder.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                 (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_rem_s  = acc_r[2*WIDTH-1:WIDTH-1];
    div_diff_s = {1'b0, div_rem_s} - {2'b00, opnd_r};
    // While rem < divisor holds, a non-negative difference always fits in WIDTH bits.
    div_ge_s   = (div_diff_s[WIDTH+1:WIDTH] == 2'b00);
    if (div_ge_s) begin
      div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_rem_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Final result selection, with divide-by-zero forced to its defined pattern.
  always_comb begin
    res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
    res_lo_s = prod_fix_s[WIDTH-1:0];
    if (dbz_r) begin
      res_hi_s = a_raw_r;
      res_lo_s = {WIDTH{1'b1}};
    end else if (is_div_r) begin
      res_hi_s = rem_fix_s;
      res_lo_s = quot_fix_s;
    end else begin
      res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Next-state logic; cancel beats start, and DONE may accept a new op directly.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) begin
          state_s  = ST_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_s = ST_IDLE;
        end else if (cnt_r == 6'(MD_ITERS - 1)) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FIX: begin
        if (cancel) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, iteration counter and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= ((state_r == ST_RUN) && (state_s == ST_RUN)) ? (cnt_r + 6'd1) : 6'd0;
      busy_r  <= (state_s == ST_RUN) || (state_s == ST_FIX);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Operand capture at accept and per-cycle accumulator update while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      a_raw_r  <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      dbz_r    <= 1'b0;
    end else if (accept_s) begin
      is_div_r <= op[1];
      a_raw_r  <= src_a;
      sign_q_r <= signed_s & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      sign_r_r <= signed_s & src_a[WIDTH-1];
      dbz_r    <= op[1] & (src_b == {WIDTH{1'b0}});
      if (op[1]) begin
        acc_r  <= {{WIDTH{1'b0}}, abs_a_s};
        opnd_r <= abs_b_s;
      end else begin
        acc_r  <= {{WIDTH{1'b0}}, abs_b_s};
        opnd_r <= abs_a_s;
      end
    end else if (state_r == ST_RUN) begin
      acc_r <= is_div_r ? div_next_s : mul_next_s;
    end
  end

  // HI/LO results update only on an uncancelled fix-up cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if ((state_r == ST_FIX) && !cancel) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
